seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.
//  Latches a packed 4-bit-per-digit value, decodes each digit (BCD or hex mode) and
//  scans digit enables at a fixed rate. Updates are tear-free (frame-boundary apply),
//  with leading-zero blanking and anti-ghost blanking. Sits between the datapath and board pins.
// PARAMETERS
//  N_DIGITS       4      number of digits scanned (>=1)
//  SCAN_DIV       50000  clk cycles each digit stays enabled (>=2)
//  BLANK_CYC      2      cycles at start of each digit slot with segments forced off (<SCAN_DIV)
//  SEG_ACTIVE_LOW 1      1: seg/seg_dp driven low = lit
//  DIG_ACTIVE_LOW 1      1: dig_sel driven low = digit enabled
// PORTS
//  clk        in   1           system clock, rising edge
//  rst_n      in   1           asynchronous reset, active low
//  load       in   1           1-cycle strobe: capture value/dp into shadow register
//  value      in   4*N_DIGITS  packed nibbles, digit 0 = value[3:0] (least significant)
//  dp         in   N_DIGITS    decimal-point request per digit
//  hex_en     in   1           1: nibbles 10..15 shown as A b C d E F; 0: shown blank
//  blank_lz   in   1           1: leading-zero blanking enabled
//  seg        out  7           segments, seg[6]=A ... seg[0]=G
//  seg_dp     out  1           decimal-point segment
//  dig_sel    out  N_DIGITS    one-hot digit enable
//  frame_tick out  1           1-cycle pulse at each frame end (after digit N_DIGITS-1 slot)
//  pending    out  1           shadow holds a value not yet applied to display
// BEHAVIOUR
//  - Reset (async, rst_n=0): scan counter=0, digit index=0, display/shadow regs=0,
//    pending=0, frame_tick=0; seg/seg_dp at unlit level, dig_sel all disabled.
//  - All outputs registered: reflect state of previous cycle (1-cycle latency).
//  - Scan: cnt runs 0..SCAN_DIV-1; at cnt=SCAN_DIV-1 cnt->0 and idx->idx+1,
//    wrapping N_DIGITS-1 -> 0. dig_sel one-hot on idx at all times after reset.
//  - Anti-ghost: while cnt<BLANK_CYC, seg and seg_dp unlit; dig_sel still enabled.
//  - Frame end = idx==N_DIGITS-1 and cnt==SCAN_DIV-1: if pending, shadow->display,
//    pending->0; frame_tick pulses the following cycle regardless of pending.
//  - load=1: value/dp -> shadow, pending->1. Later load before frame end overwrites
//    shadow (last wins). load coincident with frame end: incoming value goes
//    straight to display, pending stays 0.
//  - Decode (active-high A..G): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B
//    A=77 b=1F C=4E d=3D E=4F F=47; nibble>9 with hex_en=0 -> 00. dp bit -> seg_dp.
//  - Leading-zero blank (blank_lz=1): scanning from digit N_DIGITS-1 down, digits with
//    nibble 0 and dp 0 are unlit until first nonzero nibble or set dp; digit 0 never
//    blanked. Computed from display register, not shadow.
//  - Polarity params invert at output flops only; internal logic active-high.
//  - hex_en/blank_lz sampled live (not shadowed); change visible next cycle.
//  - Reset mid-frame: immediate return to reset state; pending load is discarded.
// STRUCTURE
//  - Package seg7_pkg: SEG_* 7-bit constants for 0..F, SEG_OFF, localparam for
//    index width $clog2(N_DIGITS) (min 1).
//  - Sub-module seg7_hex_decode: combinational nibble+hex_en -> 7-bit active-high
//    pattern; instantiated once on the muxed current digit.
//  - Top holds scan counter, idx, shadow/display regs, LZ mask, output flops.
// TESTING (N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, both ACTIVE_LOW=0)
//  - Reset: rst_n=0 mid-scan -> seg=00, seg_dp=0, dig_sel=0000, pending=0 same cycle.
//  - Scan: after reset, dig_sel 0001,0010,0100,1000,0001 each for 4 cycles;
//    frame_tick once per 16 cycles; seg=00 in first cycle of each slot.
//  - Tear-free: load value=16'h1234 mid-frame -> pending=1, display unchanged until
//    frame end; next frame digit0 seg=33, digit3 seg=30; pending=0.
//  - Hex/BCD: value=16'hABCD, hex_en=1 -> digits show 3D,4E,1F,77; hex_en=0 -> all 00.
//  - LZ blank: value=16'h0050, dp=0000, blank_lz=1 -> digits3,2 unlit, digit1=5B,
//    digit0=7E; value=0000 -> only digit0 lit 7E; dp=0100 -> digit2 lit 7E+dp.
//  - Collision: load value=16'h9999 on frame-end cycle -> displayed next frame, pending
//    never rises; second load before frame end -> only last value displayed.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan driver.
//   SEG_0..SEG_F : active-high A..G patterns (bit 6 = A, bit 0 = G)
//   SEG_OFF      : all segments unlit
//   idx_width()  : width of a digit index for n digits (never below 1)
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'h7E;
  localparam logic [6:0] SEG_1   = 7'h30;
  localparam logic [6:0] SEG_2   = 7'h6D;
  localparam logic [6:0] SEG_3   = 7'h79;
  localparam logic [6:0] SEG_4   = 7'h33;
  localparam logic [6:0] SEG_5   = 7'h5B;
  localparam logic [6:0] SEG_6   = 7'h5F;
  localparam logic [6:0] SEG_7   = 7'h70;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h7B;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h1F;
  localparam logic [6:0] SEG_C   = 7'h4E;
  localparam logic [6:0] SEG_D   = 7'h3D;
  localparam logic [6:0] SEG_E   = 7'h4F;
  localparam logic [6:0] SEG_F   = 7'h47;
  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-high 7-segment pattern.
//   nibble  in  4  digit value
//   hex_en  in  1  1: 10..15 shown as A b C d E F; 0: shown blank
//   pattern out 7  A..G, bit 6 = A
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = hex_en ? SEG_A : SEG_OFF;
      4'hB: pattern = hex_en ? SEG_B : SEG_OFF;
      4'hC: pattern = hex_en ? SEG_C : SEG_OFF;
      4'hD: pattern = hex_en ? SEG_D : SEG_OFF;
      4'hE: pattern = hex_en ? SEG_E : SEG_OFF;
      4'hF: pattern = hex_en ? SEG_F : SEG_OFF;
      default: pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit 7-segment display driver.
// A loaded value waits in a shadow register and is applied only at the end
// of a frame so a frame never shows a mix of old and new digits.
//   clk, rst_n  clock / async active-low reset
//   load        1-cycle strobe capturing value/dp into the shadow register
//   value       packed nibbles, digit 0 = value[3:0]
//   dp          decimal point request per digit
//   hex_en      show 10..15 as hex letters (else blank), live
//   blank_lz    leading-zero blanking enable, live
//   seg/seg_dp  segment outputs (polarity set by SEG_ACTIVE_LOW)
//   dig_sel     one-hot digit enable (polarity set by DIG_ACTIVE_LOW)
//   frame_tick  1-cycle pulse after the last digit slot of a frame
//   pending     shadow holds a value not yet displayed
module seg7_scan_driver #(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYC      = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  hex_en,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [N_DIGITS-1:0]   dig_sel,
  output logic                  frame_tick,
  output logic                  pending
);
  import seg7_pkg::*;

  localparam int unsigned        IDX_W     = idx_width(N_DIGITS);
  localparam int unsigned        CNT_W     = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   BLANK_LIM = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] shadow_val, disp_val;
  logic [N_DIGITS-1:0]   shadow_dp, disp_dp;
  logic                  frame_end;

  logic [N_DIGITS-1:0]   lz_mask;
  logic                  lz_seen;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_blank;
  logic [6:0]            cur_pat;
  logic [6:0]            seg_lit;
  logic                  dp_lit;
  logic [N_DIGITS-1:0]   sel_next;

  assign frame_end = (idx == IDX_LAST) && (cnt == CNT_LAST);

  // Scan counters and the shadow/display hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // A load landing exactly on the frame boundary bypasses the shadow;
      // it is newer than anything already pending, so it wins.
      if (load) begin
        if (frame_end) begin
          disp_val <= value;
          disp_dp  <= dp;
          pending  <= 1'b0;
        end else begin
          shadow_val <= value;
          shadow_dp  <= dp;
          pending    <= 1'b1;
        end
      end else if (frame_end && pending) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
        pending  <= 1'b0;
      end
    end
  end

  // Leading-zero mask: walk from the most significant digit down; blanking
  // stops at the first digit with a nonzero nibble or a lit decimal point.
  // Digit 0 is never masked.
  always_comb begin
    lz_mask = '0;
    lz_seen = 1'b0;
    for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
      if ((disp_val[i*4 +: 4] != 4'h0) || disp_dp[i]) lz_seen = 1'b1;
      lz_mask[i] = blank_lz & ~lz_seen;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    sel_next  = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib     = disp_val[i*4 +: 4];
        cur_dp      = disp_dp[i];
        cur_blank   = lz_mask[i];
        sel_next[i] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble  (cur_nib),
    .hex_en  (hex_en),
    .pattern (cur_pat)
  );

  // Anti-ghost: segments stay dark for the first BLANK_CYC cycles of a slot.
  always_comb begin
    seg_lit = cur_pat;
    dp_lit  = cur_dp;
    if ((cnt < BLANK_LIM) || cur_blank) begin
      seg_lit = SEG_OFF;
      dp_lit  = 1'b0;
    end
  end

  // Output flops: polarity applied only here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= {7{SEG_ACTIVE_LOW}};
      seg_dp  <= SEG_ACTIVE_LOW;
      dig_sel <= {N_DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      seg     <= SEG_ACTIVE_LOW ? ~seg_lit  : seg_lit;
      seg_dp  <= SEG_ACTIVE_LOW ? ~dp_lit   : dp_lit;
      dig_sel <= DIG_ACTIVE_LOW ? ~sel_next : sel_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: self-checking bench for seg7_scan_driver
// (4 digits, 4-cycle slots, 1 anti-ghost cycle, active-high outputs).
// A cycle model pushes the expected output word for every clock; the
// observed word is queued after the edge and each test drains both queues.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        hex_en;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  dig_sel;
  logic        frame_tick;
  logic        pending;

  seg7_scan_driver #(
    .N_DIGITS       (4),
    .SCAN_DIV       (4),
    .BLANK_CYC      (1),
    .SEG_ACTIVE_LOW (1'b0),
    .DIG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dp         (dp),
    .hex_en     (hex_en),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .seg_dp     (seg_dp),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Word layout: {seg[6:0], seg_dp, dig_sel[3:0], frame_tick, pending}
  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];

  int unsigned m_cnt, m_idx;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_ddp, m_sdp;
  logic        m_pend;

  logic [6:0] dec_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  function automatic string fmt(input logic [13:0] v);
    return $sformatf("seg=%h dp=%b dig=%b tick=%b pend=%b", v[13:7], v[6], v[5:2], v[1], v[0]);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 0;
    m_disp = '0; m_shadow = '0; m_ddp = '0; m_sdp = '0; m_pend = 1'b0;
  endtask

  // Expected outputs produced by the current model state (pending filled in later).
  function automatic logic [13:0] model_out();
    int unsigned top_sig;
    logic [3:0]  nib;
    logic [6:0]  s;
    logic        d;
    logic [3:0]  dig;
    logic        tick;
    top_sig = 0;
    for (int unsigned i = 0; i < 4; i++)
      if (m_disp[i*4 +: 4] != 4'h0 || m_ddp[i]) top_sig = i;
    nib  = m_disp[m_idx*4 +: 4];
    s    = (nib > 4'd9 && !hex_en) ? 7'h00 : dec_tbl[nib];
    d    = m_ddp[m_idx];
    if (m_cnt == 0 || (blank_lz && m_idx > top_sig)) begin
      s = 7'h00;
      d = 1'b0;
    end
    dig  = 4'b0001 << m_idx;
    tick = (m_idx == 3 && m_cnt == 3);
    return {s, d, dig, tick, 1'b0};
  endfunction

  // One clock: push expectation, advance model, clock DUT, capture outputs.
  task automatic cycle();
    logic [13:0] e;
    logic        fe;
    e  = model_out();
    fe = (m_idx == 3 && m_cnt == 3);
    if (load) begin
      if (fe) begin
        m_disp = value; m_ddp = dp; m_pend = 1'b0;
      end else begin
        m_shadow = value; m_sdp = dp; m_pend = 1'b1;
      end
    end else if (fe && m_pend) begin
      m_disp = m_shadow; m_ddp = m_sdp; m_pend = 1'b0;
    end
    if (m_cnt == 3) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_cnt++;
    end
    e[0] = m_pend;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    obs_q.push_back({seg, seg_dp, dig_sel, frame_tick, pending});
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    value = v; dp = p; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] e, o;
    rst_n = 1'b1; load = 1'b0; value = '0; dp = '0; hex_en = 1'b1; blank_lz = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({seg, seg_dp, dig_sel, frame_tick, pending} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_initial: actual %s required %s", fmt({seg, seg_dp, dig_sel, frame_tick, pending}), fmt(14'h0));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(6);
    do_load(16'h4321, 4'b0000);
    run(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_pre: actual %s required %s", fmt(o), fmt(e)); end
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({seg, seg_dp, dig_sel, frame_tick, pending} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_mid: actual %s required %s", fmt({seg, seg_dp, dig_sel, frame_tick, pending}), fmt(14'h0));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_post: actual %s required %s", fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_scan();
    logic [13:0] e, o;
    int ticks;
    ticks = 0;
    run(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o[1]) ticks++;
      if (o !== e) begin n_fail++; $display("FAIL scan: actual %s required %s", fmt(o), fmt(e)); end
    end
    n_checks++;
    if (ticks != 2) begin n_fail++; $display("FAIL scan_tick_count: actual %0d required 2", ticks); end
  endtask

  task automatic test_tear_free();
    logic [13:0] e, o;
    logic [6:0]  d0, d3;
    d0 = '0; d3 = '0;
    for (int k = 0; k < 16 && !(m_idx == 1 && m_cnt == 1); k++) cycle();
    do_load(16'h1234, 4'b0000);
    n_checks++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL tear_pending: actual %b required 1", pending); end
    run(40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o[5:2] == 4'b0001 && o[13:7] != 7'h00) d0 = o[13:7];
      if (o[5:2] == 4'b1000 && o[13:7] != 7'h00) d3 = o[13:7];
      if (o !== e) begin n_fail++; $display("FAIL tear_free: actual %s required %s", fmt(o), fmt(e)); end
    end
    n_checks++;
    if (d0 !== 7'h33) begin n_fail++; $display("FAIL tear_digit0: actual %h required 33", d0); end
    n_checks++;
    if (d3 !== 7'h30) begin n_fail++; $display("FAIL tear_digit3: actual %h required 30", d3); end
  endtask

  task automatic test_hex_bcd();
    logic [13:0] e, o;
    hex_en = 1'b1;
    do_load(16'hABCD, 4'b0000);
    run(36);
    hex_en = 1'b0;
    run(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL hex_bcd: actual %s required %s", fmt(o), fmt(e)); end
    end
    hex_en = 1'b1;
  endtask

  task automatic test_lz_blank();
    logic [13:0] e, o;
    blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    run(36);
    do_load(16'h0000, 4'b0000);
    run(36);
    do_load(16'h0000, 4'b0100);
    run(36);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL lz_blank: actual %s required %s", fmt(o), fmt(e)); end
    end
    blank_lz = 1'b0;
    dp = '0;
  endtask

  task automatic test_back_to_back();
    logic [13:0] e, o;
    int pend_seen;
    pend_seen = 0;
    for (int k = 0; k < 16 && !(m_idx == 3 && m_cnt == 3); k++) cycle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL collision_align: actual %s required %s", fmt(o), fmt(e)); end
    end
    do_load(16'h9999, 4'b0000);
    run(36);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o[0]) pend_seen++;
      if (o !== e) begin n_fail++; $display("FAIL collision: actual %s required %s", fmt(o), fmt(e)); end
    end
    n_checks++;
    if (pend_seen != 0) begin n_fail++; $display("FAIL collision_pending: actual %0d cycles high required 0", pend_seen); end
    for (int k = 0; k < 16 && !(m_idx == 0 && m_cnt == 2); k++) cycle();
    do_load(16'h1111, 4'b0001);
    run(3);
    do_load(16'h2222, 4'b0000);
    run(36);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL last_wins: actual %s required %s", fmt(o), fmt(e)); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_hex_bcd();
    test_lz_blank();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
